// File: rtl/hack_cpu_ctrl.sv
// Hack CPU control/register stage: fetch/exec FSM around an external ALU,
// holding A, D, PC and IR, with ROM and data-memory handshakes.
//
// state | meaning
// FETCH | wait for instr_valid, latch IR
// EXEC  | execute IR; C-instructions touching M stall until m_ready
module hack_cpu_ctrl #(
    parameter int PC_W     = 15,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [15:0]     instr_in,
    input  logic            instr_valid,
    input  logic [15:0]     in_m,
    input  logic            m_ready,
    output logic [15:0]     alu_x,
    output logic [15:0]     alu_y,
    output logic            alu_zx,
    output logic            alu_nx,
    output logic            alu_zy,
    output logic            alu_ny,
    output logic            alu_f,
    output logic            alu_no,
    input  logic [15:0]     alu_out,
    input  logic            alu_zr,
    input  logic            alu_ng,
    output logic [15:0]     out_m,
    output logic            write_m,
    output logic [PC_W-1:0] address_m,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     a_reg,
    output logic [15:0]     d_reg
);

    localparam logic [PC_W-1:0] PC_RST = RESET_PC[PC_W-1:0];

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     ir_q, ir_d;
    logic [15:0]     a_q, a_d;
    logic [15:0]     d_q, d_d;
    logic [PC_W-1:0] pc_q, pc_d;

    logic is_c, bit_a, dest_a, dest_d, dest_m, need_m, jmp;

    assign is_c   = ir_q[15];
    assign bit_a  = ir_q[12];
    assign dest_a = ir_q[5];
    assign dest_d = ir_q[4];
    assign dest_m = ir_q[3];
    assign need_m = bit_a | dest_m;
    assign jmp    = (ir_q[2] & alu_ng) | (ir_q[1] & alu_zr) | (ir_q[0] & ~alu_ng & ~alu_zr);

    assign alu_x  = d_q;
    assign alu_y  = bit_a ? in_m : a_q;
    assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ir_q[11:6];

    assign out_m     = alu_out;
    assign address_m = a_q[PC_W-1:0];
    assign pc        = pc_q;
    assign a_reg     = a_q;
    assign d_reg     = d_q;
    // Combinational from state so reset drops the strobe without a clock edge.
    assign write_m   = (state_q == EXEC) & is_c & dest_m;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            ir_q    <= '0;
            a_q     <= '0;
            d_q     <= '0;
            pc_q    <= PC_RST;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            d_q     <= d_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        a_d     = a_q;
        d_d     = d_q;
        pc_d    = pc_q;
        case (state_q)
            FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr_in;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!is_c) begin
                    a_d     = {1'b0, ir_q[14:0]};
                    pc_d    = pc_q + 1'b1;
                    state_d = FETCH;
                end else if (!(need_m && !m_ready)) begin
                    // Jump target is the A value before any dest-A update.
                    if (dest_a) a_d = alu_out;
                    if (dest_d) d_d = alu_out;
                    pc_d    = jmp ? a_q[PC_W-1:0] : pc_q + 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Self-checking bench for hack_cpu_ctrl: Hack ALU and data memory around the
// DUT, directed program steps then random instructions against a CPU model.
module tb_hack_cpu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic [15:0] in_m;
    logic        m_ready;
    logic [15:0] alu_x, alu_y, alu_out, out_m, a_reg, d_reg;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;
    logic        write_m;
    logic [14:0] address_m, pc;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem     [0:32767];
    logic [15:0] mdl_mem [0:32767];
    logic [15:0] mdl_a, mdl_d;
    logic [14:0] mdl_pc;

    always #5 clk = ~clk;

    hack_cpu_ctrl #(.PC_W(15), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .instr_valid(instr_valid),
        .in_m(in_m), .m_ready(m_ready), .alu_x(alu_x), .alu_y(alu_y),
        .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
        .alu_f(alu_f), .alu_no(alu_no), .alu_out(alu_out), .alu_zr(alu_zr),
        .alu_ng(alu_ng), .out_m(out_m), .write_m(write_m), .address_m(address_m),
        .pc(pc), .a_reg(a_reg), .d_reg(d_reg)
    );

    // Hack ALU: returns {ng, zr, out}
    function automatic logic [17:0] hack_alu(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
        logic [15:0] xx, yy, o;
        xx = c[5] ? 16'h0000 : x;
        xx = c[4] ? ~xx : xx;
        yy = c[3] ? 16'h0000 : y;
        yy = c[2] ? ~yy : yy;
        o  = c[1] ? xx + yy : xx & yy;
        o  = c[0] ? ~o : o;
        return {o[15], (o == 16'h0000), o};
    endfunction

    logic [17:0] alu_res;
    assign alu_res = hack_alu({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, alu_x, alu_y);
    assign alu_out = alu_res[15:0];
    assign alu_zr  = alu_res[16];
    assign alu_ng  = alu_res[17];
    assign in_m    = mem[address_m];

    always @(posedge clk) if (write_m && m_ready) mem[address_m] <= out_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mdl_a  = 16'h0000;
        mdl_d  = 16'h0000;
        mdl_pc = 15'h0000;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_pc"}, {17'h0, pc}, {17'h0, mdl_pc});
        chk({tag, "_a"},  {16'h0, a_reg}, {16'h0, mdl_a});
        chk({tag, "_d"},  {16'h0, d_reg}, {16'h0, mdl_d});
        chk({tag, "_wm"}, {31'h0, write_m}, 32'h0);
    endtask

    // Fetch (after fw idle cycles) and execute one instruction with up to
    // 'stall' wait cycles on M accesses, checking against the model.
    task automatic run_instr(input logic [15:0] ins, input int fw, input int stall);
        logic        is_c, need_m, jmp;
        logic [15:0] y, res;
        logic [17:0] r;
        for (int i = 0; i < fw; i++) begin
            instr_valid = 1'b0;
            instr_in    = 16'($urandom);
            m_ready     = 1'($urandom);
            tick();
            check_regs("idle");
        end
        instr_valid = 1'b1;
        instr_in    = ins;
        m_ready     = 1'($urandom);
        tick();
        instr_valid = 1'($urandom);
        instr_in    = 16'($urandom);
        is_c   = ins[15];
        need_m = is_c & (ins[12] | ins[3]);
        y      = ins[12] ? mdl_mem[mdl_a[14:0]] : mdl_a;
        r      = hack_alu(ins[11:6], mdl_d, y);
        res    = r[15:0];
        jmp    = (ins[2] & r[17]) | (ins[1] & r[16]) | (ins[0] & ~r[17] & ~r[16]);
        if (need_m) begin
            for (int s = 0; s < stall; s++) begin
                m_ready = 1'b0;
                #1;
                chk("stall_wm",   {31'h0, write_m}, {31'h0, ins[3]});
                chk("stall_outm", {16'h0, out_m}, {16'h0, res});
                chk("stall_addr", {17'h0, address_m}, {17'h0, mdl_a[14:0]});
                chk("stall_pc",   {17'h0, pc}, {17'h0, mdl_pc});
                tick();
            end
        end
        m_ready = need_m ? 1'b1 : 1'($urandom);
        #1;
        chk("exec_wm", {31'h0, write_m}, {31'h0, is_c & ins[3]});
        if (is_c) begin
            chk("exec_x", {16'h0, alu_x}, {16'h0, mdl_d});
            chk("exec_y", {16'h0, alu_y}, {16'h0, y});
            if (ins[3]) chk("exec_outm", {16'h0, out_m}, {16'h0, res});
        end
        tick();
        if (!is_c) begin
            mdl_a  = {1'b0, ins[14:0]};
            mdl_pc = mdl_pc + 15'd1;
        end else begin
            if (ins[3]) mdl_mem[mdl_a[14:0]] = res;
            mdl_pc = jmp ? mdl_a[14:0] : mdl_pc + 15'd1;
            if (ins[5]) mdl_a = res;
            if (ins[4]) mdl_d = res;
        end
        check_regs("commit");
    endtask

    initial begin
        logic [15:0] ins;
        logic [14:0] prev_pc;
        for (int i = 0; i < 32768; i++) begin
            mem[i]     = 16'($urandom);
            mdl_mem[i] = mem[i];
        end
        rst_n = 1'b0; instr_valid = 1'b0; instr_in = 16'h0; m_ready = 1'b0;
        model_reset();
        tick(); tick();
        check_regs("reset");
        rst_n = 1'b1;

        run_instr(16'h0005, 3, 0);
        run_instr(16'hEC10, 0, 0);
        chk("step2_pc", {17'h0, pc}, 32'h2);
        chk("step2_d",  {16'h0, d_reg}, 32'h5);

        run_instr(16'hE7C8, 0, 3);
        chk("step3_pc", {17'h0, pc}, 32'h3);

        run_instr(16'h0010, 0, 0);
        run_instr(16'hE301, 0, 0);
        chk("jgt_taken", {17'h0, pc}, 32'h10);
        run_instr(16'hEA90, 0, 0);
        run_instr(16'h0010, 0, 0);
        prev_pc = pc;
        run_instr(16'hE301, 0, 0);
        chk("jgt_not", {17'h0, pc}, {17'h0, prev_pc + 15'd1});

        run_instr(16'h0005, 0, 0);
        run_instr(16'hEC10, 0, 0);
        run_instr(16'h0010, 0, 0);
        run_instr(16'hE327, 0, 0);
        chk("desta_pc", {17'h0, pc}, 32'h10);
        chk("desta_a",  {16'h0, a_reg}, 32'h5);

        run_instr(16'h7FFF, 0, 0);
        run_instr(16'hEA87, 0, 0);
        chk("wrap_pre", {17'h0, pc}, 32'h7FFF);
        run_instr(16'h0000, 5, 0);
        chk("wrap_pc", {17'h0, pc}, 32'h0);

        // Reset while stalled on a memory write.
        run_instr(16'h0123, 0, 0);
        instr_valid = 1'b1; instr_in = 16'hE7C8;
        tick();
        instr_valid = 1'b0; m_ready = 1'b0;
        #1;
        chk("pre_rst_wm", {31'h0, write_m}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_regs("async_rst");
        tick();
        rst_n = 1'b1;
        run_instr(16'h0042, 4, 0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 1) == 0) ins = {1'b0, 15'($urandom)};
            else                           ins = {1'b1, 15'($urandom)};
            run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
